// File: rtl/threshold_monitor_4bit.sv
// Debounced 4-bit threshold alarm with hysteresis, run counter and optional peak hold.
// Define PEAK_HOLD_EN to build the peak register; otherwise o_peak is tied to zero.
module threshold_monitor_4bit #(
  parameter int unsigned HOLD = 3
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_sample_valid,
  input  logic [3:0] i_sample,
  input  logic [3:0] i_thr_hi,
  input  logic [3:0] i_thr_lo,
  input  logic       i_peak_clr,
  output logic       o_alarm,
  output logic       o_alarm_set,
  output logic       o_alarm_clr,
  output logic [3:0] o_run_cnt,
  output logic [1:0] o_state,
  output logic [3:0] o_peak
);

  typedef enum logic [1:0] {
    NORMAL   = 2'd0,
    ARMING   = 2'd1,
    ALARM    = 2'd2,
    CLEARING = 2'd3
  } state_t;

  localparam logic [3:0] HOLD_C = 4'(HOLD);

  state_t     r_state;
  logic [3:0] r_run_cnt;
  logic       r_alarm;
  logic       r_alarm_set;
  logic       r_alarm_clr;

  state_t     w_state_nxt;
  logic [3:0] w_run_cnt_nxt;
  logic [3:0] w_run_cnt_inc;
  logic       w_alarm_nxt;
  logic       w_set_nxt;
  logic       w_clr_nxt;
  logic       w_hi;
  logic       w_lo;

  assign w_hi          = (i_sample > i_thr_hi);
  assign w_lo          = (i_sample < i_thr_lo);
  assign w_run_cnt_inc = r_run_cnt + 4'd1;

  // Next-state, run counter and pulse decode; invalid cycles hold everything.
  always_comb begin
    w_state_nxt   = r_state;
    w_run_cnt_nxt = r_run_cnt;
    w_alarm_nxt   = r_alarm;
    w_set_nxt     = 1'b0;
    w_clr_nxt     = 1'b0;
    if (i_sample_valid) begin
      case (r_state)
        NORMAL: begin
          if (w_hi) begin
            if (HOLD_C == 4'd1) begin
              w_state_nxt   = ALARM;
              w_alarm_nxt   = 1'b1;
              w_set_nxt     = 1'b1;
              w_run_cnt_nxt = 4'd0;
            end else begin
              w_state_nxt   = ARMING;
              w_run_cnt_nxt = 4'd1;
            end
          end else begin
            w_run_cnt_nxt = 4'd0;
          end
        end
        ARMING: begin
          if (w_hi) begin
            if (w_run_cnt_inc >= HOLD_C) begin
              w_state_nxt   = ALARM;
              w_alarm_nxt   = 1'b1;
              w_set_nxt     = 1'b1;
              w_run_cnt_nxt = 4'd0;
            end else begin
              w_run_cnt_nxt = w_run_cnt_inc;
            end
          end else begin
            w_state_nxt   = NORMAL;
            w_run_cnt_nxt = 4'd0;
          end
        end
        ALARM: begin
          if (w_lo) begin
            if (HOLD_C == 4'd1) begin
              w_state_nxt   = NORMAL;
              w_alarm_nxt   = 1'b0;
              w_clr_nxt     = 1'b1;
              w_run_cnt_nxt = 4'd0;
            end else begin
              w_state_nxt   = CLEARING;
              w_run_cnt_nxt = 4'd1;
            end
          end else begin
            w_run_cnt_nxt = 4'd0;
          end
        end
        CLEARING: begin
          if (w_lo) begin
            if (w_run_cnt_inc >= HOLD_C) begin
              w_state_nxt   = NORMAL;
              w_alarm_nxt   = 1'b0;
              w_clr_nxt     = 1'b1;
              w_run_cnt_nxt = 4'd0;
            end else begin
              w_run_cnt_nxt = w_run_cnt_inc;
            end
          end else begin
            w_state_nxt   = ALARM;
            w_run_cnt_nxt = 4'd0;
          end
        end
        default: begin
          w_state_nxt   = NORMAL;
          w_alarm_nxt   = 1'b0;
          w_run_cnt_nxt = 4'd0;
        end
      endcase
    end else begin
      w_state_nxt = r_state;
    end
  end

  // State and registered outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= NORMAL;
      r_run_cnt   <= 4'd0;
      r_alarm     <= 1'b0;
      r_alarm_set <= 1'b0;
      r_alarm_clr <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_run_cnt   <= w_run_cnt_nxt;
      r_alarm     <= w_alarm_nxt;
      r_alarm_set <= w_set_nxt;
      r_alarm_clr <= w_clr_nxt;
    end
  end

`ifdef PEAK_HOLD_EN
  logic [3:0] r_peak;

  // Clear wins over the old peak, but a same-cycle valid sample is still captured.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_peak <= 4'd0;
    end else if (i_sample_valid && (i_peak_clr || (i_sample > r_peak))) begin
      r_peak <= i_sample;
    end else if (i_peak_clr) begin
      r_peak <= 4'd0;
    end else begin
      r_peak <= r_peak;
    end
  end

  assign o_peak = r_peak;
`else
  logic w_unused_peak_clr;
  assign w_unused_peak_clr = i_peak_clr;
  assign o_peak            = 4'd0;
`endif

  assign o_alarm     = r_alarm;
  assign o_alarm_set = r_alarm_set;
  assign o_alarm_clr = r_alarm_clr;
  assign o_run_cnt   = r_run_cnt;
  assign o_state     = r_state;

endmodule
